// File: rtl/cr16_control_fsm.sv
// cr16_control_fsm
// Multi-cycle controller for the CR16 datapath. It fetches one 16-bit
// instruction at a time over a req/valid handshake and decodes the register,
// immediate and Bcond subset. During one execute cycle it drives the
// datapath's write-enable, register-select, immediate, opcode and enable
// inputs. Conditional branches are resolved against the datapath's
// registered flags.
//
// Ports
//   I_CLK, I_RESET          clock (rising edge), asynchronous active-high reset
//   I_RUN                   1 = keep fetching; 0 = stop after current instruction
//   O_FETCH_REQ, O_PC       instruction request (held until I_FETCH_VALID) and
//                           word address
//   I_FETCH_VALID, I_INSTR  instruction return
//   I_STATUS_FLAGS          {N,Z,F,L,C} from the datapath
//   O_ENABLE                ALU / flag-register enable
//   O_REG_WRITE_ENABLE      one-hot register write enable
//   O_REG_A_SELECT          Rsrc select
//   O_REG_B_SELECT          Rdest select
//   O_IMMEDIATE_SELECT      immediate drives the ALU A input
//   O_IMMEDIATE             extended immediate
//   O_OPCODE                ALU opcode
//   O_HALTED                parked on an illegal instruction
module cr16_control_fsm #(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_RUN,
    output logic        O_FETCH_REQ,
    output logic [15:0] O_PC,
    input  logic        I_FETCH_VALID,
    input  logic [15:0] I_INSTR,
    input  logic [4:0]  I_STATUS_FLAGS,
    output logic        O_ENABLE,
    output logic [15:0] O_REG_WRITE_ENABLE,
    output logic [3:0]  O_REG_A_SELECT,
    output logic [3:0]  O_REG_B_SELECT,
    output logic        O_IMMEDIATE_SELECT,
    output logic [15:0] O_IMMEDIATE,
    output logic [3:0]  O_OPCODE,
    output logic        O_HALTED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;

    state_t      state;
    logic [15:0] instr_q;
    logic        branch_q;
    logic [3:0]  cond_q;
    logic [15:0] disp_q;

    logic [3:0]  op, rdest, ext, rsrc;
    logic [7:0]  imm8;
    logic [15:0] imm_sext, imm_zext;

    assign op       = instr_q[15:12];
    assign rdest    = instr_q[11:8];
    assign ext      = instr_q[7:4];
    assign rsrc     = instr_q[3:0];
    assign imm8     = instr_q[7:0];
    assign imm_sext = {{8{imm8[7]}}, imm8};
    assign imm_zext = {8'h00, imm8};

    // F and L are not consumed by any supported branch condition.
    logic unused_flags;
    assign unused_flags = ^I_STATUS_FLAGS[2:1];

    function automatic logic is_alu_code(input logic [3:0] code);
        case (code)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: is_alu_code = 1'b1;
            default:                                  is_alu_code = 1'b0;
        endcase
    endfunction

    function automatic logic is_cond_code(input logic [3:0] code);
        case (code)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'hE: is_cond_code = 1'b1;
            default:                            is_cond_code = 1'b0;
        endcase
    endfunction

    logic        dec_legal, dec_alu, dec_branch, dec_isel;
    logic [3:0]  dec_opcode, dec_a, dec_b;
    logic [15:0] dec_imm, dec_we;

    // Decode of the latched instruction. Everything defaults to zero, so an
    // illegal encoding falls out as a NOP: no enable, no write, no branch.
    // Arithmetic immediates (ADD/SUB/CMP/MOV) are sign-extended and logical
    // ones zero-extended. CMP only updates flags and never writes a register.
    always_comb begin
        dec_legal  = 1'b0;
        dec_alu    = 1'b0;
        dec_branch = 1'b0;
        dec_isel   = 1'b0;
        dec_opcode = 4'h0;
        dec_a      = 4'h0;
        dec_b      = 4'h0;
        dec_imm    = 16'h0000;
        dec_we     = 16'h0000;
        if (op == 4'h0 && is_alu_code(ext)) begin
            dec_legal  = 1'b1;
            dec_alu    = 1'b1;
            dec_opcode = ext;
            dec_a      = rsrc;
            dec_b      = rdest;
            dec_we     = (ext == OP_CMP) ? 16'h0000 : (16'h0001 << rdest);
        end else if (op != 4'h0 && is_alu_code(op)) begin
            dec_legal  = 1'b1;
            dec_alu    = 1'b1;
            dec_isel   = 1'b1;
            dec_opcode = op;
            dec_b      = rdest;
            dec_imm    = (op == 4'h1 || op == 4'h2 || op == 4'h3) ? imm_zext : imm_sext;
            dec_we     = (op == OP_CMP) ? 16'h0000 : (16'h0001 << rdest);
        end else if (op == OP_BCOND && is_cond_code(rdest)) begin
            dec_legal  = 1'b1;
            dec_branch = 1'b1;
        end
    end

    logic taken;

    // Branch resolution against the live flags during the execute cycle.
    // Flags are {N,Z,F,L,C}; GT in this subset tests N.
    always_comb begin
        taken = 1'b0;
        case (cond_q)
            4'h0:    taken = I_STATUS_FLAGS[3];
            4'h1:    taken = ~I_STATUS_FLAGS[3];
            4'h2:    taken = I_STATUS_FLAGS[0];
            4'h3:    taken = ~I_STATUS_FLAGS[0];
            4'h6:    taken = I_STATUS_FLAGS[4];
            4'hE:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Main controller. Every output is a register. Datapath controls are
    // loaded on the decode edge and cleared on the execute edge, so they are
    // non-zero only during the single execute cycle. The PC advances on the
    // execute edge, wrapping naturally at 16 bits.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state              <= S_IDLE;
            O_PC               <= RESET_PC;
            O_FETCH_REQ        <= 1'b0;
            O_ENABLE           <= 1'b0;
            O_REG_WRITE_ENABLE <= 16'h0000;
            O_REG_A_SELECT     <= 4'h0;
            O_REG_B_SELECT     <= 4'h0;
            O_IMMEDIATE_SELECT <= 1'b0;
            O_IMMEDIATE        <= 16'h0000;
            O_OPCODE           <= 4'h0;
            O_HALTED           <= 1'b0;
            instr_q            <= 16'h0000;
            branch_q           <= 1'b0;
            cond_q             <= 4'h0;
            disp_q             <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_RUN) begin
                        state       <= S_FETCH;
                        O_FETCH_REQ <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (I_FETCH_VALID) begin
                        instr_q     <= I_INSTR;
                        O_FETCH_REQ <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!dec_legal && HALT_ON_ILLEGAL) begin
                        state    <= S_HALT;
                        O_HALTED <= 1'b1;
                    end else begin
                        state              <= S_EXECUTE;
                        O_ENABLE           <= dec_alu;
                        O_REG_WRITE_ENABLE <= dec_we;
                        O_REG_A_SELECT     <= dec_a;
                        O_REG_B_SELECT     <= dec_b;
                        O_IMMEDIATE_SELECT <= dec_isel;
                        O_IMMEDIATE        <= dec_imm;
                        O_OPCODE           <= dec_opcode;
                        branch_q           <= dec_branch;
                        cond_q             <= rdest;
                        disp_q             <= imm_sext;
                    end
                end
                S_EXECUTE: begin
                    O_ENABLE           <= 1'b0;
                    O_REG_WRITE_ENABLE <= 16'h0000;
                    O_REG_A_SELECT     <= 4'h0;
                    O_REG_B_SELECT     <= 4'h0;
                    O_IMMEDIATE_SELECT <= 1'b0;
                    O_IMMEDIATE        <= 16'h0000;
                    O_OPCODE           <= 4'h0;
                    branch_q           <= 1'b0;
                    O_PC               <= (branch_q && taken) ? O_PC + disp_q : O_PC + 16'd1;
                    if (I_RUN) begin
                        state       <= S_FETCH;
                        O_FETCH_REQ <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    O_HALTED <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
